afifo_wr_arbiter: RTL
=====================

Name: afifo_wr_arbiter

Overview:
- Write-side scheduler for the async FIFO. Shares one FIFO write port (winc/wdata) round-robin among NREQ packet requesters in the wclk domain.
- Computes the write-side fill level from the Gray write pointer and the synchronised Gray read pointer.
- Grants a new packet only when the FIFO has room for a maximum-size packet, so packets are never split by other requesters.
- Sits between the requester sources and the FIFO write-pointer/full logic.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE.
- DSIZE, 8, data word width.
- NREQ, 4, number of requesters (2..8).
- PKT_MAX, 4, maximum words per packet (1..2**ADDRSIZE); also the free-space threshold for a grant.

Ports:
- wclk, input, 1, write-domain clock.
- wrst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NREQ, per-requester word valid.
- req_last, input, NREQ, per-requester last-word-of-packet flag.
- req_data, input, NREQ*DSIZE, per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready, output, NREQ, per-requester word accepted.
- wfull, input, 1, FIFO full flag (registered, from the write-pointer logic).
- wptr, input, ADDRSIZE+1, FIFO Gray write pointer.
- wq2_rptr, input, ADDRSIZE+1, Gray read pointer synchronised into wclk.
- winc, output, 1, FIFO write strobe.
- wdata, output, DSIZE, FIFO write data.
- wr_level, output, ADDRSIZE+1, registered FIFO fill level (0..2**ADDRSIZE).
- grant_id, output, clog2(NREQ), currently/last granted requester.
- busy, output, 1, packet transfer in progress.
- pkt_err, output, 1, one-cycle pulse on an overlong packet.

Behaviour:
- Reset (wrst_n low, async): state=IDLE; busy=0, grant_id=0, pkt_err=0, wr_level=0, word count=0, req_ready=0, winc=0. Round-robin last-grant pointer = NREQ-1, so requester 0 has first priority.
- Level: gray-to-binary both pointers; level_c = (wbin - rbin) mod 2**(ADDRSIZE+1).
  - wr_level <= level_c every cycle (one-cycle latency).
  - free_c = 2**ADDRSIZE - level_c (combinational). Must be correct across pointer wrap, e.g. wbin=1, rbin=30 -> level 3.
- FSM states: IDLE, XFER.
- IDLE:
  - winc=0 and req_ready=0.
  - If any req_valid and free_c >= PKT_MAX: pick the first valid requester searching from last_grant+1 (modulo NREQ). Register grant_id, set busy=1, clear the word count, go to XFER.
  - Otherwise stay in IDLE.
  - Decision uses current-cycle inputs; the first word can transfer in the cycle after the grant.
- XFER, with g = grant_id:
  - req_ready[g] = ~wfull; all other req_ready = 0.
  - winc = req_valid[g] & ~wfull (combinational).
  - wdata = req_data[g] (combinational, valid whenever winc=1).
  - Each write increments the word count.
- Packet end:
  - A write with req_last[g]=1 -> IDLE; busy=0; last_grant=g.
  - A write that makes the count = PKT_MAX with req_last[g]=0 -> pkt_err pulses 1 the next cycle, then the same IDLE/last_grant update. Remaining words of that packet re-arbitrate as a new packet.
- wfull asserted mid-packet:
  - winc=0 and req_ready=0; state, count and grant are held.
  - Requesters must hold valid/data/last stable until ready.
- req_valid[g] deasserting mid-packet is legal: no write, wait in XFER.
- Minimum one IDLE cycle between packets, so the peak throughput is PKT_MAX/(PKT_MAX+1).
- No write while wfull=1 under any condition (never overrun).
- Non-granted requesters' req_valid has no effect during XFER.
- Asynchronous reset mid-packet: immediate return to the reset values; the partial packet is abandoned.

Test Plan:
- Reset, then req_valid=4'b0101, empty FIFO, each packet 2 words -> grant 0 (wdata = req0 words, winc 2 cycles), one IDLE cycle, then grant 2; wr_level reaches 4 after the writes propagate to wptr.
- All four valid continuously, 1-word packets, reader draining -> grant order 0,1,2,3,0,1; busy toggles 1,0 per packet.
- wptr=Gray(13), wq2_rptr=Gray(0): free=3 < PKT_MAX=4 -> no grant, winc=0. wq2_rptr -> Gray(1): grant on that cycle, XFER next. Also wptr=Gray(1), wq2_rptr=Gray(30) -> wr_level=3.
- wfull=1 for 2 cycles after word 2 of a 4-word packet -> winc=0, req_ready[g]=0 for 2 cycles, then words 3,4 written in order; grant unchanged.
- Requester 1 sends 5 words with req_last only on word 5 -> 4 writes, pkt_err=1 for exactly 1 cycle, IDLE, then word 5 written as a new packet.
- wrst_n low during word 2 of a packet -> winc, req_ready, busy, grant_id, wr_level all 0 immediately; after release, requester 0 has priority.

Source files
------------

// File: rtl/afifo_wr_arbiter.sv
`timescale 1ns/1ps
// Write-side scheduler for the async FIFO: round-robin packet arbitration onto the
// single FIFO write port, granting only when a maximum-size packet is guaranteed to fit.
module afifo_wr_arbiter #(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int PKT_MAX  = 4,
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    input  logic [ADDRSIZE:0]     wptr,
    input  logic [ADDRSIZE:0]     wq2_rptr,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [ADDRSIZE:0]     wr_level,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  pkt_err
);

    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam int CW    = $clog2(PKT_MAX + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] last_grant;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic [PW-1:0] wbin_c;
    logic [PW-1:0] rbin_c;
    logic [PW-1:0] level_c;
    logic          room_c;
    logic          any_c;
    logic [GW-1:0] pick_c;
    logic          pkt_end_c;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Requester index 'off' positions after 'base', wrapping at NREQ.
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return GW'(s);
    endfunction

    // Modular subtraction keeps the level correct across pointer wrap.
    assign wbin_c  = gray2bin(wptr);
    assign rbin_c  = gray2bin(wq2_rptr);
    assign level_c = wbin_c - rbin_c;
    assign room_c  = ({1'b0, level_c} + (PW+1)'(PKT_MAX)) <= (PW+1)'(DEPTH);

    always_comb begin
        any_c  = 1'b0;
        pick_c = last_grant;
        for (int i = 1; i <= NREQ; i++) begin
            if (!any_c && req_valid[rr_idx(last_grant, i)]) begin
                any_c  = 1'b1;
                pick_c = rr_idx(last_grant, i);
            end
        end
    end

    always_comb begin
        winc      = 1'b0;
        req_ready = '0;
        wdata     = req_data[grant_id*DSIZE +: DSIZE];
        if (state == XFER && !wfull) begin
            req_ready[grant_id] = 1'b1;
            winc                = req_valid[grant_id];
        end
    end

    assign busy      = (state == XFER);
    assign cnt_nxt   = cnt + CW'(1);
    assign pkt_end_c = req_last[grant_id] || (cnt_nxt == CW'(PKT_MAX));

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
            cnt        <= '0;
            pkt_err    <= 1'b0;
            wr_level   <= '0;
        end else begin
            wr_level <= level_c;
            pkt_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_c && room_c) begin
                        grant_id <= pick_c;
                        cnt      <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (winc) begin
                        cnt <= cnt_nxt;
                        // An overlong packet is cut here; its tail re-arbitrates later.
                        if (pkt_end_c) begin
                            pkt_err    <= ~req_last[grant_id];
                            last_grant <= grant_id;
                            state      <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
